// File: rtl/mult_tb_pkg.sv
// mult_tb_pkg: shared widths, pipeline depth and checker FSM states for the multiplication-table flow
package mult_tb_pkg;
    localparam int DW = 8;
    localparam int PW = 16;
    localparam int LATENCY = 3;
    localparam int DEPTH = 128;
    typedef enum logic [1:0] {ST_IDLE, ST_COLLECT, ST_DRAIN, ST_DONE} state_t;
endpackage

// File: rtl/mult_align_delay.sv
// mult_align_delay: LATENCY-stage shift register that lines issued operands up with the returning product
module mult_align_delay #(
    parameter int LATENCY = 3,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_pipe [LATENCY];
    // shift one stage per cycle; reset empties every stage so no stale valid survives
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= i_d;
            for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
        end
    end
    assign o_q = r_pipe[LATENCY-1];
endmodule

// File: rtl/mult_table_checker.sv
// mult_table_checker: aligns operands with multiplier products, checks them against a running golden value and stores them
module mult_table_checker #(
    parameter int DW = mult_tb_pkg::DW,
    parameter int PW = mult_tb_pkg::PW,
    parameter int LATENCY = mult_tb_pkg::LATENCY,
    parameter int DEPTH = mult_tb_pkg::DEPTH,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic          i_in_valid,
    input  logic [DW-1:0] i_in_a,
    input  logic [DW-1:0] i_in_b,
    input  logic          i_in_last,
    input  logic [PW-1:0] i_p,
    input  logic [AW-1:0] i_rd_addr,
    output logic [PW-1:0] o_rd_data,
    output logic          o_busy,
    output logic          o_done,
    output logic [AW:0]   o_entry_cnt,
    output logic [7:0]    o_err_cnt,
    output logic [AW:0]   o_first_err_idx,
    output logic          o_overflow
);
    import mult_tb_pkg::*;
    localparam int SW = 2*DW + 2;
    state_t r_state, w_next;
    logic [SW-1:0] w_dl_in, w_dl_out;
    logic w_d_vld, w_d_last, w_first, w_cont, w_seq_err, w_mis, w_err, w_full;
    logic [DW-1:0] w_d_a, w_d_b, r_prev_a, r_prev_b;
    logic [PW-1:0] w_exp, r_prev_exp, r_rd_raw;
    logic [PW-1:0] r_mem [DEPTH];
    logic [AW:0] r_entry_cnt, r_first_err;
    logic [7:0] r_err_cnt;
    logic r_overflow, r_rd_ok;
    // only operands issued while collecting enter the delay line
    assign w_dl_in = {i_in_valid && r_state == ST_COLLECT, i_in_a, i_in_b, i_in_last};
    assign {w_d_vld, w_d_a, w_d_b, w_d_last} = w_dl_out;
    mult_align_delay #(.LATENCY(LATENCY), .W(SW)) u_dly (
        .clk (clk),
        .rst (rst),
        .i_d (w_dl_in),
        .o_q (w_dl_out)
    );
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else r_state <= w_next;
    end
    // next-state: DONE lasts exactly one cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    w_next = i_start ? ST_COLLECT : ST_IDLE;
            ST_COLLECT: w_next = (i_in_valid && i_in_last) ? ST_DRAIN : ST_COLLECT;
            ST_DRAIN:   w_next = (w_d_vld && w_d_last) ? ST_DONE : ST_DRAIN;
            default:    w_next = ST_IDLE;
        endcase
    end
    // golden value: a row restart seeds with b, a continued row adds b, anything else resyncs to p
    assign w_first = w_d_a == DW'(1);
    assign w_cont = w_d_a == r_prev_a + DW'(1) && w_d_b == r_prev_b;
    assign w_exp = w_first ? PW'(w_d_b) : w_cont ? r_prev_exp + PW'(w_d_b) : i_p;
    assign w_seq_err = !w_first && !w_cont;
    assign w_mis = i_p != w_exp;
    assign w_err = w_seq_err || w_mis;
    assign w_full = r_entry_cnt == (AW+1)'(DEPTH);
    // run bookkeeping: cleared on start, updated once per aligned result, held after the run
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (r_state == ST_IDLE && i_start)) begin
            r_entry_cnt <= '0;
            r_err_cnt <= '0;
            r_first_err <= '1;
            r_overflow <= 1'b0;
            r_prev_a <= '0;
            r_prev_b <= '0;
            r_prev_exp <= '0;
        end else if (w_d_vld) begin
            r_prev_a <= w_d_a;
            r_prev_b <= w_d_b;
            r_prev_exp <= w_exp;
            if (w_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            if (w_err && r_first_err == '1) r_first_err <= r_entry_cnt;
            if (w_full) r_overflow <= 1'b1;
            else r_entry_cnt <= r_entry_cnt + 1'b1;
        end
    end
    // result table: write at the current count, registered read returns pre-write data
    always_ff @(posedge clk) begin
        if (w_d_vld && !w_full) r_mem[r_entry_cnt[AW-1:0]] <= i_p;
        r_rd_raw <= r_mem[i_rd_addr];
    end
    // entries beyond the current count read back as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_ok <= 1'b0;
        else r_rd_ok <= {1'b0, i_rd_addr} < r_entry_cnt;
    end
    assign o_rd_data = r_rd_ok ? r_rd_raw : '0;
    assign o_busy = r_state == ST_COLLECT || r_state == ST_DRAIN;
    assign o_done = r_state == ST_DONE;
    assign o_entry_cnt = r_entry_cnt;
    assign o_err_cnt = r_err_cnt;
    assign o_first_err_idx = r_first_err;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_mult_table_checker.sv
// tb_mult_table_checker: randomized runs against a reference model, checked through a scoreboard monitor
module tb_mult_table_checker;
    localparam int LAT = 3;
    localparam int K_RD = 0;
    localparam int K_ST = 1;
    typedef struct {int cyc; int kind; int v0; int v1; int v2; int v3; int v4;} exp_t;
    logic clk = 1'b0, rst = 1'b1;
    logic i_start = 1'b0, i_in_valid = 1'b0, i_in_last = 1'b0;
    logic [7:0] i_in_a = '0, i_in_b = '0;
    logic [15:0] i_p = '0;
    logic [6:0] i_rd_addr = '0;
    logic [15:0] o_rd_data;
    logic o_busy, o_done, o_overflow;
    logic [7:0] o_entry_cnt, o_err_cnt, o_first_err_idx;
    int cyc = 0, total = 0, bad = 0;
    int qa[$], qb[$], qp[$];
    logic [15:0] pq[$];
    exp_t chk_q[$], done_q[$], mon_e;
    int m_ent = 0, m_err = 0, m_fe = 255, m_ov = 0;
    int m_tbl[128];

    mult_table_checker dut (
        .clk (clk), .rst (rst), .i_start (i_start), .i_in_valid (i_in_valid),
        .i_in_a (i_in_a), .i_in_b (i_in_b), .i_in_last (i_in_last), .i_p (i_p),
        .i_rd_addr (i_rd_addr), .o_rd_data (o_rd_data), .o_busy (o_busy), .o_done (o_done),
        .o_entry_cnt (o_entry_cnt), .o_err_cnt (o_err_cnt), .o_first_err_idx (o_first_err_idx),
        .o_overflow (o_overflow)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        while (chk_q.size() > 0 && chk_q[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL stale_check: due cycle %0d, not reached by cycle %0d", chk_q[0].cyc, cyc);
            void'(chk_q.pop_front());
        end
        while (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
            mon_e = chk_q.pop_front();
            if (mon_e.kind == K_RD) chk("rd_data", int'(o_rd_data), mon_e.v0);
            else begin
                chk("entry_cnt", int'(o_entry_cnt), mon_e.v0);
                chk("err_cnt", int'(o_err_cnt), mon_e.v1);
                chk("first_err_idx", int'(o_first_err_idx), mon_e.v2);
                chk("overflow", int'(o_overflow), mon_e.v3);
                chk("busy", int'(o_busy), mon_e.v4);
            end
        end
        if (o_done) begin
            if (done_q.size() == 0) begin
                total++; bad++;
                $display("FAIL spurious_done: got done=1 expected done=0 (cycle %0d)", cyc);
            end else begin
                mon_e = done_q.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_entry_cnt", int'(o_entry_cnt), mon_e.v0);
                chk("done_err_cnt", int'(o_err_cnt), mon_e.v1);
                chk("done_first_err_idx", int'(o_first_err_idx), mon_e.v2);
                chk("done_overflow", int'(o_overflow), mon_e.v3);
            end
        end
        if (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            total++; bad++;
            $display("FAIL missing_done: got none expected done at cycle %0d", done_q[0].cyc);
            void'(done_q.pop_front());
        end
    end

    // one clock of stimulus; the multiplier model returns pv LAT cycles later
    task automatic drive(input bit v, input int a, input int b, input bit last, input int pv, input bit st);
        @(posedge clk); #1;
        i_start = st; i_in_valid = v; i_in_a = 8'(a); i_in_b = 8'(b); i_in_last = last;
        i_p = pq.pop_front();
        pq.push_back(v ? 16'(pv) : 16'h0);
    endtask

    task automatic rd(input int addr);
        drive(0, 0, 0, 0, 0, 0);
        i_rd_addr = 7'(addr);
        chk_q.push_back('{cyc + 1, K_RD, (addr < m_ent) ? m_tbl[addr] : 0, 0, 0, 0, 0});
    endtask

    task automatic push_status(input int busy);
        chk_q.push_back('{cyc, K_ST, m_ent, m_err, m_fe, m_ov, busy});
    endtask

    // table rows: a counts 1..rowlen then restarts with b+1; optional skipped a and corrupted product
    task automatic gen(input int n, input int b0, input int rowlen, input int err_at, input int skip_at);
        int a, b;
        a = 1; b = b0;
        qa.delete(); qb.delete(); qp.delete();
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                if (a >= rowlen) begin a = 1; b++; end
                else a += (i == skip_at) ? 2 : 1;
            end
            qa.push_back(a); qb.push_back(b);
            qp.push_back((a * b + ((i == err_at) ? 6 : 0)) & 16'hFFFF);
        end
    endtask

    // reference: walk the issued results with the golden rules using plain integers
    task automatic model();
        int pa, pb, pe, e, a, b, p, errs;
        pa = 0; pb = 0; pe = 0;
        m_err = 0; m_fe = 255; m_ov = 0;
        for (int i = 0; i < qa.size(); i++) begin
            a = qa[i]; b = qb[i]; p = qp[i]; errs = 0;
            if (a == 1) e = b;
            else if (a == pa + 1 && b == pb) e = (pe + b) & 16'hFFFF;
            else begin errs++; e = p; end
            if (p != e) errs++;
            m_err = (m_err + errs > 255) ? 255 : m_err + errs;
            if (errs > 0 && m_fe == 255) m_fe = (i < 128) ? i : 128;
            if (i < 128) m_tbl[i] = p; else m_ov = 1;
            pa = a; pb = b; pe = e;
        end
        m_ent = (qa.size() < 128) ? qa.size() : 128;
    endtask

    task automatic do_run(input bit noise);
        int n;
        n = qa.size();
        drive(noise, $urandom_range(0, 255), $urandom_range(0, 255), 0, 0, 1);
        for (int i = 0; i < n; i++) begin
            if (noise && $urandom_range(0, 3) == 0) drive(0, 0, 0, 0, 0, 1);
            drive(1, qa[i], qb[i], i == n - 1, qp[i], noise && $urandom_range(0, 1) == 1);
        end
        model();
        done_q.push_back('{cyc + LAT + 1, 2, m_ent, m_err, m_fe, m_ov, 0});
        for (int k = 0; k < LAT + 3; k++)
            drive(noise && k < 2, $urandom_range(1, 255), $urandom_range(0, 255), noise && k == 0, 0, 0);
        push_status(0);
        rd(0); rd(4); rd((n - 1 > 127) ? 127 : n - 1); rd((n > 127) ? 127 : n); rd($urandom_range(0, 127));
        if (noise) begin
            drive(1, 1, 3, 1, 0, 0);
            drive(0, 0, 0, 0, 0, 0);
            push_status(0);
        end
    endtask

    task automatic abort_run();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) drive(1, i + 1, 5, 0, (i + 1) * 5, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        i_start = 1'b0; i_in_valid = 1'b0;
        void'(pq.pop_front()); pq.push_back(16'h0);
        m_ent = 0; m_err = 0; m_fe = 255; m_ov = 0;
        push_status(0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (LAT + 4) drive(0, 0, 0, 0, 0, 0);
        push_status(0);
    endtask

    initial begin
        int n, ea, sk;
        repeat (LAT) pq.push_back(16'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        push_status(0);
        rd(5);
        gen(9, 2, 100, -1, -1); do_run(0);
        gen(9, 2, 100, 4, -1); do_run(0);
        gen(4, 3, 100, -1, 2); do_run(0);
        gen(130, 2, 17, 129, -1); do_run(0);
        abort_run();
        gen(9, 2, 100, -1, -1); do_run(1);
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(1, 40);
            ea = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
            sk = ($urandom_range(0, 2) == 0) ? $urandom_range(1, n) : -1;
            gen(n, $urandom_range(1, 20), $urandom_range(2, 12), ea, sk);
            do_run($urandom_range(0, 1) == 1);
        end
        repeat (5) drive(0, 0, 0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
